load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_pkg.sv | 50 +++++
 rtl/load_store_unit_if.sv | 28 ++
 rtl/load_store_unit.sv | 95 +++++++++
 tb/tb_load_store_unit.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Load/store unit shared types: FSM state encoding, RV32I width codes,
// and the funct3 legality / natural-alignment checks used at accept time.
package lsu_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACCESS  = 2'd1,
    S_CAPTURE = 2'd2,
    S_RESP    = 2'd3
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  function automatic logic f3_legal(
    input logic       we,
    input logic [2:0] f3
  );
    logic ok;
    ok = 1'b0;
    unique case (1'b1)
      (f3 == F3_B),
      (f3 == F3_H),
      (f3 == F3_W):  ok = 1'b1;
      (f3 == F3_BU),
      (f3 == F3_HU): ok = !we;
      default:       ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic f3_aligned(
    input logic [2:0] f3,
    input logic [1:0] lsb
  );
    logic ok;
    ok = 1'b1;
    unique case (1'b1)
      (f3 == F3_H),
      (f3 == F3_HU): ok = !lsb[0];
      (f3 == F3_W):  ok = (lsb == 2'b00);
      default:       ok = 1'b1;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// CPU-side request/response handshake of the load/store unit.
// master = CPU (drives req_*, resp_ready); slave = LSU.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_funct3,
    output req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid,
    input  resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3,
    input  req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid,
    output resp_rdata, resp_err
  );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store unit: one access at a time, IDLE->ACCESS->(CAPTURE)->RESP.
// Ports: clk, rst_n, bus (load_store_unit_if.slave), mem_* memory side.
// Optional: LSU_MISALIGN_CHECK_EN flags misaligned H/W accesses as errors.
import lsu_pkg::*;

module load_store_unit #(
  parameter logic [2:0] IDLE_FUNCT3 = 3'b010
) (
  input  logic                     clk,
  input  logic                     rst_n,
  load_store_unit_if.slave         bus,
  output logic                     mem_write,
  output logic [2:0]               mem_funct3,
  output logic [31:0]              mem_write_address,
  output logic [31:0]              mem_read_address,
  output logic [31:0]              mem_write_data,
  input  logic [31:0]              mem_read_data
);

  lsu_state_e  state_q;
  lsu_state_e  state_d;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic        accept;
  logic        legal;

  assign accept = bus.req_valid && bus.req_ready;

`ifdef LSU_MISALIGN_CHECK_EN
  assign legal = f3_legal(bus.req_we, bus.req_funct3)
              && f3_aligned(bus.req_funct3, bus.req_addr[1:0]);
`else
  assign legal = f3_legal(bus.req_we, bus.req_funct3);
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:
        if (accept)
          state_d = legal ? S_ACCESS : S_RESP;
      S_ACCESS:
        state_d = we_q ? S_RESP : S_CAPTURE;
      S_CAPTURE:
        state_d = S_RESP;
      S_RESP:
        if (bus.resp_ready)
          state_d = S_IDLE;
      default:
        state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q    <= bus.req_we;
        f3_q    <= bus.req_funct3;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
        rdata_q <= '0;
        err_q   <= !legal;
      end
      if (state_q == S_CAPTURE)
        rdata_q <= mem_read_data;
    end
  end

  // rst_n gates ready so nothing is accepted while reset is held
  assign bus.req_ready  = rst_n && (state_q == S_IDLE);
  assign bus.resp_valid = (state_q == S_RESP);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;

  // state-only decode: async reset to IDLE drops the strobe at once
  assign mem_write = (state_q == S_ACCESS) && we_q;
  assign mem_funct3 = (state_q == S_IDLE) ? IDLE_FUNCT3 : f3_q;
  assign mem_write_address = addr_q;
  assign mem_read_address  = addr_q;
  assign mem_write_data    = wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a byte-addressed
// synchronous memory model behind it.
module tb_load_store_unit;

  logic        clk;
  logic        rst_n;
  logic        mem_write;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_write_address;
  logic [31:0] mem_read_address;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  int n_chk;
  int n_pass;
  int wr_cnt;

  load_store_unit_if bus ();

  load_store_unit #(.IDLE_FUNCT3(3'b010)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .bus               (bus),
    .mem_write         (mem_write),
    .mem_funct3        (mem_funct3),
    .mem_write_address (mem_write_address),
    .mem_read_address  (mem_read_address),
    .mem_write_data    (mem_write_data),
    .mem_read_data     (mem_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] mem [logic [31:0]];

  function automatic logic [7:0] rd8(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 8'h00;
  endfunction

  always @(posedge clk) begin : mem_model
    logic [31:0] a;
    logic [31:0] w;
    logic [31:0] r;
    a = mem_write_address;
    if (mem_write) begin
      wr_cnt++;
      mem[a] = mem_write_data[7:0];
      if (mem_funct3 != 3'b000)
        mem[a + 32'd1] = mem_write_data[15:8];
      if (mem_funct3 == 3'b010) begin
        mem[a + 32'd2] = mem_write_data[23:16];
        mem[a + 32'd3] = mem_write_data[31:24];
      end
    end
    a = mem_read_address;
    w = {rd8(a + 32'd3), rd8(a + 32'd2), rd8(a + 32'd1), rd8(a)};
    case (mem_funct3)
      3'b000:  r = {{24{w[7]}}, w[7:0]};
      3'b001:  r = {{16{w[15]}}, w[15:0]};
      3'b100:  r = {24'h0, w[7:0]};
      3'b101:  r = {16'h0, w[15:0]};
      default: r = w;
    endcase
    mem_read_data <= r;
  end

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, exp);
  endtask

  // Called right after a post-edge sample point; returns there too.
  task automatic run(
    input string       tag,
    input logic        we,
    input logic [2:0]  f3,
    input logic [31:0] addr,
    input logic [31:0] wdata,
    input logic [31:0] exp_rdata,
    input logic        exp_err,
    input int          exp_lat,
    input int          hold
  );
    int wr0;
    int lat;
    wr0 = wr_cnt;
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    chk({tag, "_ready"}, bus.req_ready, 1'b1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    if (!exp_err) begin
      chk({tag, "_maddr"}, mem_read_address, addr);
      chk({tag, "_mf3"}, mem_funct3, f3);
      if (we)
        chk({tag, "_mwd"}, mem_write_data, wdata);
    end
    lat = 1;
    while (!bus.resp_valid && lat < 8) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_rdata"}, bus.resp_rdata, exp_rdata);
    chk({tag, "_err"}, bus.resp_err, exp_err);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      chk({tag, "_hv"}, bus.resp_valid, 1'b1);
      chk({tag, "_hrdy"}, bus.req_ready, 1'b0);
      chk({tag, "_hrd"}, bus.resp_rdata, exp_rdata);
      chk({tag, "_herr"}, bus.resp_err, exp_err);
    end
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.resp_ready = 1'b0;
    chk({tag, "_done"}, bus.resp_valid, 1'b0);
    chk({tag, "_wr"}, 32'(wr_cnt - wr0),
        (we && !exp_err) ? 32'd1 : 32'd0);
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    wr_cnt = 0;
    rst_n  = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.resp_ready = 1'b0;

    #3;
    chk("rst_ready", bus.req_ready, 1'b0);
    chk("rst_rvalid", bus.resp_valid, 1'b0);
    chk("rst_err", bus.resp_err, 1'b0);
    chk("rst_rdata", bus.resp_rdata, 32'h0);
    chk("rst_mw", mem_write, 1'b0);
    chk("rst_waddr", mem_write_address, 32'h0);
    chk("rst_raddr", mem_read_address, 32'h0);
    chk("rst_wdata", mem_write_data, 32'h0);
    chk("rst_mf3", mem_funct3, 3'b010);

    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rel_ready", bus.req_ready, 1'b1);

    run("sw10", 1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 0, 2, 0);
    run("lw10", 0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 0, 3, 0);
    run("lb13", 0, 3'b000, 32'h13, 32'h0, 32'hFFFFFFDE, 0, 3, 0);
    run("lbu13", 0, 3'b100, 32'h13, 32'h0, 32'h000000DE, 0, 3, 0);
    run("lhu12", 0, 3'b101, 32'h12, 32'h0, 32'h0000DEAD, 0, 3, 0);
    run("lh12", 0, 3'b001, 32'h12, 32'h0, 32'hFFFFDEAD, 0, 3, 0);
    run("shled", 1, 3'b001, 32'hFFFFFFFE, 32'h1234, 32'h0, 0, 2, 0);
    run("lwled", 0, 3'b010, 32'hFFFFFFFC, 32'h0, 32'h12340000, 0, 3, 0);
    run("sb11", 1, 3'b000, 32'h21, 32'hA5A5A55A, 32'h0, 0, 2, 0);
    run("lw20", 0, 3'b010, 32'h20, 32'h0, 32'h00005A00, 0, 3, 0);
`ifdef LSU_MISALIGN_CHECK_EN
    run("lw12", 0, 3'b010, 32'h12, 32'h0, 32'h0, 1, 1, 0);
    run("sh11", 1, 3'b001, 32'h11, 32'hFFFF, 32'h0, 1, 1, 0);
`else
    run("lw12", 0, 3'b010, 32'h12, 32'h0, 32'h0000DEAD, 0, 3, 0);
`endif
    run("ld011", 0, 3'b011, 32'h10, 32'h0, 32'h0, 1, 1, 0);
    run("st100", 1, 3'b100, 32'h10, 32'h0, 32'h0, 1, 1, 0);
    run("hold", 0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 0, 3, 5);

    chk("idle_mf3", mem_funct3, 3'b010);
    chk("idle_raddr", mem_read_address, 32'h10);
    chk("idle_waddr", mem_write_address, 32'h10);
    chk("idle_mw", mem_write, 1'b0);

    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_funct3 = 3'b010;
    bus.req_addr   = 32'h10;
    bus.req_wdata  = 32'h11111111;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    chk("ab_mw_hi", mem_write, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("ab_mw_lo", mem_write, 1'b0);
    chk("ab_ready", bus.req_ready, 1'b0);
    chk("ab_rvalid", bus.resp_valid, 1'b0);
    chk("ab_mf3", mem_funct3, 3'b010);
    chk("ab_addr", mem_write_address, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("ab_rel_rdy", bus.req_ready, 1'b1);
    chk("ab_norsp", bus.resp_valid, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("ab_norsp2", bus.resp_valid, 1'b0);
    run("ab_lw10", 0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 0, 3, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
